// File: rtl/spi_master_rr_arbiter_18bit.sv
// ---------------------------------------------------------------------------
// spi_master_rr_arbiter_18bit
// Round-robin arbiter that shares one single-CS SPI master among NUM_REQ
// requesters. Each requester holds a level request plus its TX word; the
// arbiter hands the word to the master via TX_DV, waits for RX_DV (or a
// timeout), and returns the response to the requester that owned the
// transfer. A CS-recovery gap separates consecutive transfers.
//
// Ports
//   i_Clk, i_Rst        clock, asynchronous active-high reset
//   i_Req_DV            per-requester level request
//   i_Req_Word          flattened TX words, requester k at [k*WORD_W +: WORD_W]
//   o_Req_Ack           one-hot 1-cycle accept pulse
//   o_Rsp_DV            one-hot 1-cycle response pulse
//   o_Rsp_Word          received word (0 on timeout), held until next response
//   o_Rsp_Timeout       1 = response produced by timeout
//   o_TX_Byte, o_TX_DV  word and strobe to the SPI master
//   i_TX_Ready          SPI master ready
//   i_RX_DV, i_RX_Byte  SPI master receive strobe and word
//   o_Busy              high whenever the FSM is not idle
//   o_Grant_Idx         current or last owner
//
// States
//   IDLE    | arbitrate when the master is ready and someone requests
//   ISSUE   | one cycle: TX_DV + Ack to the winner
//   WAIT_RX | wait for RX_DV or timeout
//   GAP     | CS recovery, then wait for master ready
// ---------------------------------------------------------------------------
module spi_master_rr_arbiter_18bit #(
  parameter int NUM_REQ      = 4,
  parameter int WORD_W       = 18,
  parameter int TIMEOUT_CLKS = 1024,
  parameter int GAP_CLKS     = 4
) (
  input  logic                         i_Clk,
  input  logic                         i_Rst,
  input  logic [NUM_REQ-1:0]           i_Req_DV,
  input  logic [NUM_REQ*WORD_W-1:0]    i_Req_Word,
  output logic [NUM_REQ-1:0]           o_Req_Ack,
  output logic [NUM_REQ-1:0]           o_Rsp_DV,
  output logic [WORD_W-1:0]            o_Rsp_Word,
  output logic                         o_Rsp_Timeout,
  output logic [WORD_W-1:0]            o_TX_Byte,
  output logic                         o_TX_DV,
  input  logic                         i_TX_Ready,
  input  logic                         i_RX_DV,
  input  logic [WORD_W-1:0]            i_RX_Byte,
  output logic                         o_Busy,
  output logic [$clog2(NUM_REQ)-1:0]   o_Grant_Idx
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CW    = IDX_W + 1;
  localparam int TO_W  = $clog2(TIMEOUT_CLKS + 1);
  // A zero gap still needs a 1-bit counter so the vector is legal.
  localparam int GAP_W = (GAP_CLKS > 0) ? $clog2(GAP_CLKS + 1) : 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT_RX = 2'd2,
    ST_GAP     = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    rr_q, rr_d;
  logic [IDX_W-1:0]    grant_q, grant_d;
  logic [WORD_W-1:0]   tx_byte_q, tx_byte_d;
  logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
  logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;
  logic [WORD_W-1:0]   rsp_word_q, rsp_word_d;
  logic                rsp_timeout_q, rsp_timeout_d;
  logic [NUM_REQ-1:0]  rsp_dv_q, rsp_dv_d;

  logic                win_found;
  logic [IDX_W-1:0]    win_idx;
  logic [CW-1:0]       cand;

  // Scan upward from rr pointer + 1, wrapping; the last winner is checked
  // last so a continuously requesting owner drops to lowest priority.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = {1'b0, rr_q} + CW'(i);
      if (cand >= CW'(NUM_REQ)) cand = cand - CW'(NUM_REQ);
      if (!win_found && i_Req_DV[cand[IDX_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[IDX_W-1:0];
      end
    end
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state_q       <= ST_IDLE;
      rr_q          <= IDX_W'(NUM_REQ - 1);
      grant_q       <= '0;
      tx_byte_q     <= '0;
      to_cnt_q      <= '0;
      gap_cnt_q     <= '0;
      rsp_word_q    <= '0;
      rsp_timeout_q <= 1'b0;
      rsp_dv_q      <= '0;
    end else begin
      state_q       <= state_d;
      rr_q          <= rr_d;
      grant_q       <= grant_d;
      tx_byte_q     <= tx_byte_d;
      to_cnt_q      <= to_cnt_d;
      gap_cnt_q     <= gap_cnt_d;
      rsp_word_q    <= rsp_word_d;
      rsp_timeout_q <= rsp_timeout_d;
      rsp_dv_q      <= rsp_dv_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    rr_d          = rr_q;
    grant_d       = grant_q;
    tx_byte_d     = tx_byte_q;
    to_cnt_d      = to_cnt_q;
    gap_cnt_d     = gap_cnt_q;
    rsp_word_d    = rsp_word_q;
    rsp_timeout_d = rsp_timeout_q;
    rsp_dv_d      = '0;
    case (state_q)
      ST_IDLE: begin
        if (i_TX_Ready && win_found) begin
          grant_d   = win_idx;
          rr_d      = win_idx;
          tx_byte_d = i_Req_Word[win_idx*WORD_W +: WORD_W];
          state_d   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        to_cnt_d = '0;
        state_d  = ST_WAIT_RX;
      end
      ST_WAIT_RX: begin
        // RX_DV is checked first so it wins over a coincident timeout.
        if (i_RX_DV) begin
          rsp_word_d        = i_RX_Byte;
          rsp_timeout_d     = 1'b0;
          rsp_dv_d[grant_q] = 1'b1;
          gap_cnt_d         = GAP_W'(GAP_CLKS);
          state_d           = ST_GAP;
        end else if (to_cnt_q == TO_W'(TIMEOUT_CLKS - 1)) begin
          rsp_word_d        = '0;
          rsp_timeout_d     = 1'b1;
          rsp_dv_d[grant_q] = 1'b1;
          gap_cnt_d         = GAP_W'(GAP_CLKS);
          state_d           = ST_GAP;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      ST_GAP: begin
        if (gap_cnt_q != '0) begin
          gap_cnt_d = gap_cnt_q - 1'b1;
        end else if (i_TX_Ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    o_Req_Ack = '0;
    o_TX_DV   = 1'b0;
    if (state_q == ST_ISSUE) begin
      o_TX_DV            = 1'b1;
      o_Req_Ack[grant_q] = 1'b1;
    end
    o_Busy        = (state_q != ST_IDLE);
    o_TX_Byte     = tx_byte_q;
    o_Grant_Idx   = grant_q;
    o_Rsp_DV      = rsp_dv_q;
    o_Rsp_Word    = rsp_word_q;
    o_Rsp_Timeout = rsp_timeout_q;
  end

endmodule

// File: tb/tb_spi_master_rr_arbiter_18bit.sv
// ---------------------------------------------------------------------------
// Bench for spi_master_rr_arbiter_18bit (NUM_REQ=4, WORD_W=18,
// TIMEOUT_CLKS=16, GAP_CLKS=4). The bench plays both the requesters and the
// SPI master. A round-robin pointer model predicts each winner; response
// timing and values are predicted from the handshake rules.
// ---------------------------------------------------------------------------
module tb_spi_master_rr_arbiter_18bit;

  localparam int NUM_REQ      = 4;
  localparam int WORD_W       = 18;
  localparam int TIMEOUT_CLKS = 16;
  localparam int GAP_CLKS     = 4;
  localparam int IW           = $clog2(NUM_REQ);

  logic                       clk = 1'b0;
  logic                       rst;
  logic [NUM_REQ-1:0]         req_dv;
  logic [NUM_REQ*WORD_W-1:0]  req_word;
  logic [NUM_REQ-1:0]         req_ack;
  logic [NUM_REQ-1:0]         rsp_dv;
  logic [WORD_W-1:0]          rsp_word;
  logic                       rsp_timeout;
  logic [WORD_W-1:0]          tx_byte;
  logic                       tx_dv;
  logic                       tx_ready;
  logic                       rx_dv;
  logic [WORD_W-1:0]          rx_byte;
  logic                       busy;
  logic [IW-1:0]              grant_idx;

  spi_master_rr_arbiter_18bit #(
    .NUM_REQ(NUM_REQ), .WORD_W(WORD_W),
    .TIMEOUT_CLKS(TIMEOUT_CLKS), .GAP_CLKS(GAP_CLKS)
  ) dut (
    .i_Clk(clk), .i_Rst(rst),
    .i_Req_DV(req_dv), .i_Req_Word(req_word),
    .o_Req_Ack(req_ack), .o_Rsp_DV(rsp_dv),
    .o_Rsp_Word(rsp_word), .o_Rsp_Timeout(rsp_timeout),
    .o_TX_Byte(tx_byte), .o_TX_DV(tx_dv), .i_TX_Ready(tx_ready),
    .i_RX_DV(rx_dv), .i_RX_Byte(rx_byte),
    .o_Busy(busy), .o_Grant_Idx(grant_idx)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int model_ptr = NUM_REQ - 1;
  int last_tx_cyc = -1;
  bit force_words = 1'b0;
  logic [WORD_W-1:0] forced_word = '0;
  logic [WORD_W-1:0] forced_rx = '0;
  logic [WORD_W-1:0] last_rx = '0;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Round-robin reference: first requester after the last winner, wrapping.
  function automatic int model_pick(input logic [NUM_REQ-1:0] mask);
    for (int off = 1; off <= NUM_REQ; off++) begin
      int idx;
      idx = (model_ptr + off) % NUM_REQ;
      if (((mask >> idx) & NUM_REQ'(1)) != '0) return idx;
    end
    return -1;
  endfunction

  task automatic apply_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    model_ptr   = NUM_REQ - 1;
    last_tx_cyc = -1;
    tick();
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 60) begin
      tick();
      n++;
    end
    checks++;
    if (busy) begin
      errors++;
      $display("FAIL wait_idle: busy still %b after %0d cycles, need 0", busy, n);
    end
  endtask

  // One complete transfer. rx_delay < 0 means the master never answers.
  task automatic do_transfer(input logic [NUM_REQ-1:0] mask, input int rx_delay,
                             input bit keep_req, output int winner, output int lat);
    logic [NUM_REQ*WORD_W-1:0] words;
    logic [NUM_REQ-1:0]        exp_oh;
    logic [WORD_W-1:0]         rxw;
    int n;
    bit seen;
    for (int k = 0; k < NUM_REQ; k++)
      words[k*WORD_W +: WORD_W] = force_words ? forced_word : WORD_W'($urandom);
    req_word  = words;
    req_dv    = mask;
    winner    = model_pick(mask);
    model_ptr = winner;
    exp_oh    = NUM_REQ'(1) << winner;
    seen = 1'b0;
    n    = 0;
    while (!seen && n < 60) begin
      tick();
      n++;
      if (tx_dv) seen = 1'b1;
    end
    lat = n;
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL tx_dv_wait: no TX_DV within %0d cycles", n);
      return;
    end
    checks++;
    if (req_ack !== exp_oh) begin
      errors++;
      $display("FAIL ack: got %b need %b", req_ack, exp_oh);
    end
    checks++;
    if (grant_idx !== IW'(winner)) begin
      errors++;
      $display("FAIL grant_idx: got %0d need %0d", grant_idx, winner);
    end
    checks++;
    if (tx_byte !== words[winner*WORD_W +: WORD_W]) begin
      errors++;
      $display("FAIL tx_byte: got %h need %h", tx_byte, words[winner*WORD_W +: WORD_W]);
    end
    if (last_tx_cyc >= 0) begin
      checks++;
      if (cyc - last_tx_cyc < GAP_CLKS + 3) begin
        errors++;
        $display("FAIL tx_spacing: got %0d cycles need >= %0d", cyc - last_tx_cyc, GAP_CLKS + 3);
      end
    end
    last_tx_cyc = cyc;
    if (!keep_req) req_dv[winner] = 1'b0;
    // Words change after acceptance; the transfer in flight must not.
    for (int k = 0; k < NUM_REQ; k++) req_word[k*WORD_W +: WORD_W] = WORD_W'($urandom);
    tick();
    checks++;
    if (tx_dv !== 1'b0 || busy !== 1'b1 || tx_byte !== words[winner*WORD_W +: WORD_W]) begin
      errors++;
      $display("FAIL wait_rx_entry: tx_dv=%b busy=%b tx_byte=%h need 0 1 %h",
               tx_dv, busy, tx_byte, words[winner*WORD_W +: WORD_W]);
    end
    if (rx_delay >= 0) begin
      repeat (rx_delay) tick();
      rxw     = force_words ? forced_rx : WORD_W'($urandom);
      rx_dv   = 1'b1;
      rx_byte = rxw;
      tick();
      rx_dv   = 1'b0;
      last_rx = rxw;
      checks++;
      if (rsp_dv !== exp_oh || rsp_word !== rxw || rsp_timeout !== 1'b0) begin
        errors++;
        $display("FAIL rsp: dv=%b word=%h to=%b need dv=%b word=%h to=0",
                 rsp_dv, rsp_word, rsp_timeout, exp_oh, rxw);
      end
    end else begin
      n = 0;
      while (rsp_dv == '0 && n < 40) begin
        tick();
        n++;
      end
      last_rx = '0;
      checks++;
      if (n != TIMEOUT_CLKS || rsp_dv !== exp_oh || rsp_word !== '0 || rsp_timeout !== 1'b1) begin
        errors++;
        $display("FAIL timeout_rsp: after %0d cycles dv=%b word=%h to=%b need %0d %b 0 1",
                 n, rsp_dv, rsp_word, rsp_timeout, TIMEOUT_CLKS, exp_oh);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    checks++;
    if ({req_ack, rsp_dv, rsp_word, rsp_timeout, tx_byte, tx_dv, busy, grant_idx} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: ack=%b rsp_dv=%b word=%h to=%b tx=%h tx_dv=%b busy=%b grant=%0d need all 0",
               req_ack, rsp_dv, rsp_word, rsp_timeout, tx_byte, tx_dv, busy, grant_idx);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    int w, lat;
    force_words = 1'b1;
    forced_word = 18'h3AAAA;
    forced_rx   = 18'h2A5A5;
    do_transfer(4'b0001, 2, 1'b0, w, lat);
    force_words = 1'b0;
    checks++;
    if (lat != 1) begin
      errors++;
      $display("FAIL single_latency: got %0d need 1", lat);
    end
  endtask

  task automatic test_rr_order();
    int w, lat;
    apply_reset();
    do_transfer(4'b0110, 1, 1'b0, w, lat);
    do_transfer(4'b0100, 1, 1'b0, w, lat);
    // All four held continuously: expected 3,0,1,2,3.
    for (int i = 0; i < 5; i++) do_transfer(4'b1111, $urandom_range(0, 4), 1'b1, w, lat);
    req_dv = '0;
  endtask

  task automatic test_random();
    int w, lat, d;
    logic [NUM_REQ-1:0] m;
    for (int i = 0; i < 10; i++) begin
      m = NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1));
      d = ($urandom_range(0, 5) == 0) ? -1 : $urandom_range(0, 12);
      do_transfer(m, d, 1'b0, w, lat);
    end
    req_dv = '0;
  endtask

  task automatic test_timeout();
    int w, lat;
    do_transfer(4'b0010, -1, 1'b0, w, lat);
    do_transfer(4'b0001, 3, 1'b0, w, lat);
  endtask

  task automatic test_rx_ignored();
    int w, lat;
    wait_idle();
    req_dv  = '0;
    rx_dv   = 1'b1;
    rx_byte = 18'h15555;
    tick();
    rx_dv = 1'b0;
    checks++;
    if (rsp_dv !== '0 || busy !== 1'b0 || rsp_word !== last_rx) begin
      errors++;
      $display("FAIL rx_in_idle: rsp_dv=%b busy=%b word=%h need 0 0 %h", rsp_dv, busy, rsp_word, last_rx);
    end
    do_transfer(4'b1000, 0, 1'b0, w, lat);
    rx_dv   = 1'b1;
    rx_byte = ~last_rx;
    tick();
    rx_dv = 1'b0;
    checks++;
    if (rsp_dv !== '0 || busy !== 1'b1 || rsp_word !== last_rx) begin
      errors++;
      $display("FAIL rx_in_gap: rsp_dv=%b busy=%b word=%h need 0 1 %h", rsp_dv, busy, rsp_word, last_rx);
    end
  endtask

  task automatic test_reset_mid();
    int w, lat, n;
    bit seen, spurious;
    wait_idle();
    req_dv = 4'b0100;
    seen = 1'b0;
    n = 0;
    while (!seen && n < 30) begin
      tick();
      n++;
      if (tx_dv) seen = 1'b1;
    end
    req_dv = '0;
    tick();
    tick();
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({req_ack, rsp_dv, rsp_word, rsp_timeout, tx_byte, tx_dv, busy, grant_idx} !== '0) begin
      errors++;
      $display("FAIL async_reset: busy=%b grant=%0d tx=%h word=%h to=%b need all 0",
               busy, grant_idx, tx_byte, rsp_word, rsp_timeout);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_ptr   = NUM_REQ - 1;
    last_tx_cyc = -1;
    rx_dv   = 1'b1;
    rx_byte = 18'h0F0F0;
    tick();
    rx_dv = 1'b0;
    spurious = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (rsp_dv != '0) spurious = 1'b1;
      tick();
    end
    checks++;
    if (spurious) begin
      errors++;
      $display("FAIL reset_no_rsp: got a Rsp_DV after reset, need none");
    end
    do_transfer(4'b1111, 1, 1'b0, w, lat);
    req_dv = '0;
  endtask

  task automatic test_ready();
    logic [NUM_REQ-1:0] exp_oh;
    int w;
    bit bad;
    wait_idle();
    tx_ready = 1'b0;
    req_dv   = 4'b0001;
    req_word[0 +: WORD_W] = 18'h12345;
    bad = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (tx_dv !== 1'b0 || req_ack !== '0 || busy !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL ready_low: tx_dv=%b ack=%b busy=%b need 0 0 0", tx_dv, req_ack, busy);
    end
    tx_ready  = 1'b1;
    w         = model_pick(4'b0001);
    model_ptr = w;
    exp_oh    = NUM_REQ'(1) << w;
    tick();
    checks++;
    if (tx_dv !== 1'b1 || req_ack !== exp_oh || tx_byte !== 18'h12345) begin
      errors++;
      $display("FAIL ready_rise: tx_dv=%b ack=%b tx=%h need 1 %b 12345", tx_dv, req_ack, tx_byte, exp_oh);
    end
    last_tx_cyc = cyc;
    req_dv = '0;
    tick();
    rx_dv   = 1'b1;
    rx_byte = 18'h00001;
    tick();
    rx_dv   = 1'b0;
    last_rx = 18'h00001;
  endtask

  task automatic test_back_to_back();
    int w, lat;
    // Fastest possible master: exercises the minimum TX_DV spacing.
    for (int i = 0; i < 3; i++) do_transfer(4'b0011, 0, 1'b1, w, lat);
    req_dv = '0;
  endtask

  initial begin
    rst      = 1'b1;
    req_dv   = '0;
    req_word = '0;
    tx_ready = 1'b1;
    rx_dv    = 1'b0;
    rx_byte  = '0;
    test_reset();
    test_single();
    test_rr_order();
    test_timeout();
    test_random();
    test_rx_ignored();
    test_reset_mid();
    test_ready();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_master_rr_arbiter_18bit.md
Name: spi_master_rr_arbiter_18bit

Overview:
- Round-robin arbiter sharing one 18-bit single-CS SPI master among NUM_REQ requesters (e.g. ADC poller, DAC writer, config engine).
- Accepts one 18-bit word per requester, issues it through the master's TX_DV/TX_Ready handshake, and waits for the master's RX_DV.
- Returns the received 18-bit word, or a timeout flag, to the requester that owned the transfer.
- Sits between requester logic and the SPI master, one clock domain.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- WORD_W, 18, SPI word width; must match the master's BIT_PER_TRANSFER.
- TIMEOUT_CLKS, 1024, i_Clk cycles allowed in WAIT_RX before the transfer is aborted.
- GAP_CLKS, 4, minimum idle i_Clk cycles between transfers (CS recovery).

Ports:
- i_Clk  in  1  system clock.
- i_Rst  in  1  asynchronous reset, active-high.
- i_Req_DV  in  NUM_REQ  per-requester level request; held until the matching o_Req_Ack.
- i_Req_Word  in  NUM_REQ*WORD_W  flattened TX words; requester k uses bits [k*WORD_W +: WORD_W].
- o_Req_Ack  out  NUM_REQ  one-hot, 1-cycle pulse when that requester's word is accepted.
- o_Rsp_DV  out  NUM_REQ  one-hot, 1-cycle pulse when that requester's response is valid.
- o_Rsp_Word  out  WORD_W  received word; valid with o_Rsp_DV.
- o_Rsp_Timeout  out  1  qualifies o_Rsp_DV; 1 means the transfer timed out.
- o_TX_Byte  out  WORD_W  word to the SPI master.
- o_TX_DV  out  1  1-cycle pulse to the SPI master.
- i_TX_Ready  in  1  SPI master ready.
- i_RX_DV  in  1  SPI master RX data valid pulse.
- i_RX_Byte  in  WORD_W  SPI master RX word.
- o_Busy  out  1  high in every state except IDLE.
- o_Grant_Idx  out  clog2(NUM_REQ)  index of the current or last owner.

Behaviour:
- Reset values: all outputs 0; state = IDLE; rr pointer = NUM_REQ-1, so requester 0 has first priority.
- Registers:
  - rr pointer: index of the last granted requester.
  - grant index.
  - timeout counter: clog2(TIMEOUT_CLKS+1) bits.
  - gap counter.
- FSM states: IDLE, ISSUE, WAIT_RX, GAP.
- IDLE:
  - Arbitrate only when i_TX_Ready=1 and |i_Req_DV.
  - Winner is the first set bit scanning upward from rr pointer+1, wrapping modulo NUM_REQ.
  - Latch the winner's word into o_TX_Byte and set grant and rr pointer to the winner.
  - Go to ISSUE.
- ISSUE (exactly 1 cycle):
  - o_TX_DV=1 and o_Req_Ack[grant]=1 in the same cycle; o_TX_Byte is stable.
  - Clear the timeout counter and go to WAIT_RX.
  - Latency: request seen in IDLE at cycle N gives TX_DV/Ack at cycle N+1.
- WAIT_RX:
  - On i_RX_DV=1: register o_Rsp_Word=i_RX_Byte and o_Rsp_Timeout=0. Pulse o_Rsp_DV[grant] the next cycle. Go to GAP.
  - Otherwise increment the counter.
  - When the counter reaches TIMEOUT_CLKS-1 without RX_DV: o_Rsp_Word=0, o_Rsp_Timeout=1, pulse o_Rsp_DV[grant], go to GAP.
  - If RX_DV and the timeout occur in the same cycle, RX_DV wins.
- GAP:
  - Count GAP_CLKS cycles, then wait for i_TX_Ready=1, then go to IDLE.
  - GAP_CLKS=0 means only the ready wait.
- o_Rsp_Word and o_Rsp_Timeout hold their values until the next response.
- i_RX_DV outside WAIT_RX is ignored: no o_Rsp_DV.
- i_Req_DV changes outside IDLE are ignored; a request dropped before Ack is simply not served.
- The word is sampled only in the IDLE arbitration cycle; later changes to i_Req_Word do not affect the transfer in flight.
- Back-to-back from one requester: after GAP, that requester gets lowest priority if others are requesting.
- Reset mid-transfer: everything returns to reset values immediately; no Rsp_DV is generated for the aborted transfer.
- o_TX_DV is never asserted while i_TX_Ready=0 was sampled in IDLE. It is never asserted twice for one Ack.

Test Plan:
- Single request, word 18'h3AAAA:
  - req0 asserted with ready=1 → TX_DV + Ack[0] one cycle later with TX_Byte=3AAAA.
  - Bench master returns RX 18'h2A5A5 → Rsp_DV[0]=1, Rsp_Word=2A5A5, Timeout=0.
- req1 and req2 asserted together after reset → req1 served first, then req2. Then with all four held continuously, grant order is 3,0,1,2,3 with no starvation.
- No RX_DV after TX_DV (TIMEOUT_CLKS=16) → Rsp_DV[grant] exactly 16 cycles after entering WAIT_RX with Timeout=1 and Word=0; next request proceeds normally.
- RX_DV pulse in IDLE and a second RX_DV during GAP → no Rsp_DV, no state change.
- i_Rst pulsed in WAIT_RX → outputs 0 immediately (asynchronous), no Rsp_DV; a later request is granted to req0 first.
- i_TX_Ready held 0 with req0 pending → no Ack and no TX_DV; ready rises → TX_DV follows one cycle later. Also check GAP of GAP_CLKS=4 cycles minimum between consecutive TX_DV pulses.
